// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add multiplier (MULT/MULTU style) with IDLE/CALC/FIX/DONE control.
// Optional signed support is compiled in with MULT_SIGNED_EN; default build is unsigned only.
module mult_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       fsm_state
);

  // Handshake: start is a level sampled only in IDLE; busy is high from the accept
  // edge until the edge leaving DONE; done is a one-cycle pulse with hi/lo valid.
  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;
  logic               neg;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_start;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] result;

`ifdef MULT_SIGNED_EN
  always_comb begin
    mag_a     = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    mag_b     = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    neg_start = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
  end
`else
  always_comb begin
    mag_a     = op_a;
    mag_b     = op_b;
    neg_start = 1'b0 & is_signed;
  end
`endif

  // Upper half plus multiplicand in WIDTH+1 bits; the carry becomes the new product MSB.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
    result = neg ? -acc : acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      neg   <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= mag_a;
            acc   <= {{WIDTH{1'b0}}, mag_b};
            cnt   <= '0;
            neg   <= neg_start;
            state <= S_CALC;
          end
        end
        S_CALC: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            acc <= {sum, acc[WIDTH-1:1]};
            if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
            else cnt <= cnt + CW'(1);
          end
        end
        S_FIX: begin
          if (abort) begin
            state <= S_IDLE;
          end else begin
            {hi, lo} <= result;
            state    <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: cycle-accurate timeline model with a product queue, directed
// literal checks and a randomized phase. Honours MULT_SIGNED_EN like the design.
module tb_mult_seq_ctrl;

  localparam int W   = 32;
  localparam int LAT = W + 2;

`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         is_signed;
  logic         abort;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed), .abort(abort),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .hi(hi), .lo(lo),
    .fsm_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = {{W{1'b0}}, a};
    eb = {{W{1'b0}}, b};
    if (s && SIGNED_EN) begin
      ea = {{W{a[W-1]}}, a};
      eb = {{W{b[W-1]}}, b};
    end
    return ea * eb;
  endfunction

  // Operation timeline: age 1..W compute, W+1 fix-up, W+2 done pulse.
  logic         m_active;
  int           m_age;
  logic [W-1:0] m_hi;
  logic [W-1:0] m_lo;
  logic [2*W-1:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_age    <= 0;
      m_hi     <= '0;
      m_lo     <= '0;
      exp_q.delete();
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_age    <= 1;
        exp_q.push_back(ref_prod(op_a, op_b, is_signed));
      end
    end else if (m_age == LAT) begin
      m_active <= 1'b0;
    end else if (abort) begin
      m_active <= 1'b0;
      exp_q.delete();
    end else begin
      if (m_age == LAT - 1) {m_hi, m_lo} <= exp_q.pop_front();
      m_age <= m_age + 1;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      vectors++;
      if (busy !== m_active || done !== (m_active && m_age == LAT) ||
          hi !== m_hi || lo !== m_lo) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: got busy=%b done=%b hi=%h lo=%h expected busy=%b done=%b hi=%h lo=%h",
                 $time, busy, done, hi, lo, m_active, (m_active && m_age == LAT), m_hi, m_lo);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Issue one op from IDLE; returns cycles from start cycle to the done cycle (-1 on timeout).
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output int lat);
    op_a = a; op_b = b; is_signed = s; start = 1'b1; lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int ndone;
    int dq[$];
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    @(posedge clk); #1;

    // Unsigned full-scale product and latency
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    chk("latency_u", lat, 34);
    chk("ffxff_hi", hi, 32'hFFFF_FFFE);
    chk("ffxff_lo", lo, 32'h0000_0001);

    // -1 x 5 with is_signed set
    do_op(32'hFFFF_FFFF, 32'h0000_0005, 1'b1, lat);
    chk("latency_s", lat, 34);
    chk("m1x5_hi", hi, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004);
    chk("m1x5_lo", lo, 32'hFFFF_FFFB);

    // Second start while busy must be dropped
    op_a = 7; op_b = 6; is_signed = 1'b0; start = 1'b1; ndone = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge clk); #1;
      start = (k == 10);
      if (k == 10) begin op_a = 3; op_b = 3; end
      if (done) ndone++;
    end
    chk("collision_dones", ndone, 1);
    chk("collision_hi", hi, 0);
    chk("collision_lo", lo, 42);

    // Abort mid-compute keeps the previous result
    op_a = 100; op_b = 100; start = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 42);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    do_op(2, 3, 1'b0, lat);
    chk("after_abort_lo", lo, 6);

    // Asynchronous reset mid-compute
    op_a = 32'h1234_5678; op_b = 32'h9ABC_DEF0; start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(11, 13, 1'b0, lat);
    chk("post_rst_lat", lat, 34);
    chk("post_rst_lo", lo, 143);

    // Abort landing in the fix-up cycle: result must not be written
    op_a = 50; op_b = 50; start = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("fix_abort_busy", busy, 0);
    chk("fix_abort_lo", lo, 143);

    // abort together with start in IDLE: start wins
    abort = 1'b1;
    do_op(9, 9, 1'b0, lat);
    chk("abort_start_lat", lat, 34);
    chk("abort_start_lo", lo, 81);

    // Back-to-back with start held high
    op_a = 32'h8000_0000; op_b = 2; is_signed = 1'b0; start = 1'b1;
    for (int k = 1; k <= 120; k++) begin
      @(posedge clk); #1;
      if (done) dq.push_back(k);
    end
    start = 1'b0;
    chk("b2b_count", dq.size(), 3);
    if (dq.size() == 3) begin
      chk("b2b_first", dq[0], 34);
      chk("b2b_gap1", dq[1] - dq[0], 35);
      chk("b2b_gap2", dq[2] - dq[1], 35);
    end
    chk("b2b_hi", hi, 1);
    chk("b2b_lo", lo, 0);
    repeat (40) @(posedge clk);
    #1;

    // Randomized phase checked every cycle by the model
    for (int k = 0; k < 2500; k++) begin
      start     = ($urandom_range(0, 3) == 0);
      abort     = ($urandom_range(0, 40) == 0);
      is_signed = $urandom_range(0, 1);
      op_a      = pick_operand();
      op_b      = pick_operand();
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (50) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, operand width; product is 2*WIDTH bits.
REQ-002 clk  input  1  rising-edge clock, sole clock domain.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start.
REQ-006 abort  input  1  synchronous cancel of an in-flight operation.
REQ-007 op_a  input  WIDTH  multiplicand; sampled with start.
REQ-008 op_b  input  WIDTH  multiplier; sampled with start.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when hi/lo are updated.
REQ-011 hi  output  WIDTH  upper product half (HI register).
REQ-012 lo  output  WIDTH  lower product half (LO register).

Function
REQ-013 States SHALL be IDLE, CALC, FIX, DONE; encoding is implementation choice.
REQ-014 In IDLE, start=1 SHALL latch op_a, op_b and is_signed, clear the partial product and counter, and enter CALC.
REQ-015 In IDLE, start=0 SHALL keep the state and leave hi/lo unchanged.
REQ-016 CALC SHALL run exactly WIDTH cycles, one multiplier bit per cycle: if the current LSB is 1, add the multiplicand magnitude to the upper half; then shift {carry, acc} right by 1.
REQ-017 The adder SHALL be WIDTH+1 bits wide, with the carry shifted into the product MSB, so unsigned overflow never occurs.
REQ-018 The counter SHALL be clog2(WIDTH)+1 bits; CALC SHALL exit to FIX when the count reaches WIDTH-1 and that iteration completes.
REQ-019 FIX SHALL last one cycle and apply sign correction (REQ-029/030), then write the 2*WIDTH-bit result to {hi, lo}.
REQ-020 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-021 Total latency: done is high in the cycle WIDTH+2 edges after the start-accept edge (34 for WIDTH=32).
REQ-022 busy SHALL rise on the edge after start is accepted and fall on the edge that leaves DONE.
REQ-023 start while busy SHALL be ignored, with no queuing.
REQ-024 start coincident with the DONE cycle SHALL be ignored; it is accepted only on a later IDLE cycle.
REQ-025 hi/lo SHALL change only on the FIX->DONE edge; they hold their old values during CALC.
REQ-026 abort in CALC or FIX SHALL return to IDLE next edge, without done and with hi/lo unchanged; abort in IDLE or DONE has no effect.
REQ-027 If abort and start are high together in IDLE, start SHALL be accepted.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and internal operand registers to 0, including when it occurs mid-operation.

Configuration
REQ-029 With MULT_SIGNED_EN defined: when is_signed=1, operands SHALL be converted to magnitudes at start.
REQ-030 With MULT_SIGNED_EN defined: when is_signed=1, FIX SHALL negate the 2*WIDTH-bit result when the operand signs differ.
REQ-031 Without MULT_SIGNED_EN: is_signed SHALL be ignored, all operations SHALL be unsigned, and FIX SHALL still take one cycle so latency is unchanged.

Verification
REQ-032 Unsigned: op_a=0xFFFFFFFF, op_b=0xFFFFFFFF, is_signed=0 -> done at +34 cycles, hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 Signed (macro defined): op_a=0xFFFFFFFF (-1), op_b=0x00000005, is_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFFB; without the macro -> hi=0x00000004, lo=0xFFFFFFFB.
REQ-034 Busy collision: start on 7x6, then start again at cycle +10 with 3x3 -> only one done; hi=0, lo=42; the second request is ignored.
REQ-035 Abort: start on 100x100, abort at cycle +15 -> busy=0 next cycle, no done, hi/lo keep the prior result; a subsequent 2x3 yields lo=6.
REQ-036 Reset mid-CALC: rst_n low at cycle +20 -> busy, done, hi and lo are 0 immediately; after release, a new start completes normally.
REQ-037 Back-to-back: start held high continuously with 0x80000000 x 2 -> a done every 35 cycles (34 + 1 IDLE), hi=0x00000001, lo=0.
